// File: rtl/addern_mult_ctrl_if.sv
// ============================================================================
// Module   : addern_mult_ctrl_if
// Brief    : Operand/result and external-adder bus of the shift-add multiplier.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface addern_mult_ctrl_if #(
    parameter int N = 4
);
    logic             Start;
    logic [N-1:0]     A;
    logic [N-1:0]     B;
    logic [N-1:0]     Add_X;
    logic [N-1:0]     Add_Y;
    logic             Add_Cin;
    logic [N-1:0]     Add_S;
    logic             Add_Cout;
    logic             Busy;
    logic             Done;
    logic [2*N-1:0]   Product;

    modport master (
        output Start, A, B, Add_S, Add_Cout,
        input  Add_X, Add_Y, Add_Cin, Busy, Done, Product
    );

    modport slave (
        input  Start, A, B, Add_S, Add_Cout,
        output Add_X, Add_Y, Add_Cin, Busy, Done, Product
    );
endinterface

`default_nettype wire

// File: rtl/addern_mult_ctrl.sv
// ============================================================================
// Module   : addern_mult_ctrl
// Brief    : Shift-add unsigned multiplier sequencing an external N-bit adder.
//            Optional MULT_ZERO_BYPASS_EN finishes zero-operand starts at once.
// Revision : 1.0
// ============================================================================
`default_nettype none

module addern_mult_ctrl #(
    parameter int N = 4
) (
    input  wire logic          Clock,
    input  wire logic          Reset,
    addern_mult_ctrl_if.slave  bus
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADD   = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    mcand_q, mcand_d;
    logic [N-1:0]    phi_q,   phi_d;
    logic [N-1:0]    q_q,     q_d;
    logic            c_q,     c_d;
    logic [CW-1:0]   cnt_q,   cnt_d;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_IDLE;
            mcand_q <= '0;
            phi_q   <= '0;
            q_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            phi_q   <= phi_d;
            q_q     <= q_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        phi_d   = phi_q;
        q_d     = q_q;
        c_d     = c_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.Start) begin
                    mcand_d = bus.A;
                    q_d     = bus.B;
                    phi_d   = '0;
                    c_d     = 1'b0;
                    cnt_d   = CW'(N);
                    state_d = S_ADD;
`ifdef MULT_ZERO_BYPASS_EN
                    // Product is {P_hi, Q}, so Q must be cleared too for a zero result
                    if ((bus.A == '0) || (bus.B == '0)) begin
                        q_d     = '0;
                        state_d = S_DONE;
                    end
`endif
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_ADD: begin
                if (q_q[0]) begin
                    {c_d, phi_d} = {bus.Add_Cout, bus.Add_S};
                end else begin
                    c_d = 1'b0;
                end
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                {c_d, phi_d, q_d} = {1'b0, c_q, phi_q, q_q[N-1:1]};
                cnt_d             = cnt_q - CW'(1);
                state_d           = (cnt_d != '0) ? S_ADD : S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.Add_X   = phi_q;
    assign bus.Add_Y   = mcand_q;
    assign bus.Add_Cin = 1'b0;
    assign bus.Busy    = (state_q == S_ADD) || (state_q == S_SHIFT);
    assign bus.Done    = (state_q == S_DONE);
    assign bus.Product = {phi_q, q_q};

endmodule

`default_nettype wire

// File: tb/tb_addern_mult_ctrl.sv
// ============================================================================
// Module   : tb_addern_mult_ctrl
// Brief    : Self-checking bench for addern_mult_ctrl with a behavioural adder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_addern_mult_ctrl;

    localparam int N = 4;
`ifdef MULT_ZERO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct {
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic [2*N-1:0] p;
    } vec_t;

    typedef struct {
        logic [2*N-1:0] p;
        int             start;
        int             lat;
        int             busy;
    } exp_t;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   busy_run = 0;
    bit   cout_seen = 1'b0;
    exp_t exp_q[$];
    vec_t vecs[10];

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    addern_mult_ctrl_if #(.N(N)) bus ();

    addern_mult_ctrl #(.N(N)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    // External Addern model
    assign {bus.Add_Cout, bus.Add_S} = {1'b0, bus.Add_X} + {1'b0, bus.Add_Y}
                                     + {{N{1'b0}}, bus.Add_Cin};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic push_exp(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2*N-1:0] p);
        exp_t e;
        bit   zero;
        zero    = (a == '0) || (b == '0);
        e.p     = p;
        e.start = cyc;
        e.lat   = (BYPASS && zero) ? 1 : 2*N + 1;
        e.busy  = (BYPASS && zero) ? 0 : 2*N;
        exp_q.push_back(e);
    endtask

    task automatic drive_start(input logic [N-1:0] a, input logic [N-1:0] b,
                               input logic [2*N-1:0] p);
        bus.Start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        push_exp(a, b, p);
        step();
        bus.Start = 1'b0;
    endtask

    task automatic wait_idle(input logic [2*N-1:0] p);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
        if (exp_q.size() != 0) begin
            check("done_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        check("hold_product", 64'(bus.Product), 64'(p));
        check("idle_busy", 64'(bus.Busy), 64'd0);
        check("idle_done", 64'(bus.Done), 64'd0);
    endtask

    task automatic run_one(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2*N-1:0] p);
        drive_start(a, b, p);
        wait_idle(p);
    endtask

    // Scoreboard: every Done pops one expectation; first busy cycle of a run is ADD
    always @(negedge Clock) begin
        exp_t e;
        if (bus.Busy) begin
            if ((busy_run % 2 == 0) && bus.Add_Cout) cout_seen = 1'b1;
            busy_run++;
        end else if (bus.Done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("product", 64'(bus.Product), 64'(e.p));
                check("latency", 64'(cyc - e.start), 64'(e.lat));
                check("busy_cycles", 64'(busy_run), 64'(e.busy));
            end
            busy_run = 0;
        end else begin
            busy_run = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{4'd13, 4'd11, 8'h8F};
        vecs[1] = '{4'd15, 4'd15, 8'hE1};
        vecs[2] = '{4'd0,  4'd9,  8'h00};
        vecs[3] = '{4'd9,  4'd0,  8'h00};
        vecs[4] = '{4'd1,  4'd1,  8'h01};
        vecs[5] = '{4'd15, 4'd1,  8'h0F};
        vecs[6] = '{4'd1,  4'd15, 8'h0F};
        vecs[7] = '{4'd8,  4'd8,  8'h40};
        vecs[8] = '{4'd12, 4'd10, 8'h78};
        vecs[9] = '{4'd7,  4'd9,  8'h3F};

        bus.Start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        Reset     = 1'b1;
        repeat (3) step();
        check("rst_busy", 64'(bus.Busy), 64'd0);
        check("rst_done", 64'(bus.Done), 64'd0);
        check("rst_product", 64'(bus.Product), 64'd0);
        check("rst_add_x", 64'(bus.Add_X), 64'd0);
        check("rst_add_y", 64'(bus.Add_Y), 64'd0);
        check("rst_add_cin", 64'(bus.Add_Cin), 64'd0);
        Reset = 1'b0;
        step();

        for (int i = 0; i < 10; i++) run_one(vecs[i].a, vecs[i].b, vecs[i].p);

        cout_seen = 1'b0;
        run_one(4'd15, 4'd15, 8'hE1);
        check("cout_on_add", 64'(cout_seen), 64'd1);

        // Start while busy must not disturb the latched operands
        drive_start(4'd5, 4'd3, 8'h0F);
        repeat (3) step();
        bus.Start = 1'b1;
        bus.A     = 4'd7;
        bus.B     = 4'd7;
        step();
        bus.Start = 1'b0;
        wait_idle(8'h0F);
        repeat (12) step();

        // Reset during the 4th SHIFT aborts with no Done
        drive_start(4'd9, 4'd9, 8'h51);
        repeat (7) step();
        check("busy_before_abort", 64'(bus.Busy), 64'd1);
        Reset = 1'b1;
        exp_q.delete();
        step();
        Reset = 1'b0;
        check("abort_busy", 64'(bus.Busy), 64'd0);
        check("abort_done", 64'(bus.Done), 64'd0);
        check("abort_product", 64'(bus.Product), 64'd0);
        check("abort_add_x", 64'(bus.Add_X), 64'd0);
        check("abort_add_y", 64'(bus.Add_Y), 64'd0);
        repeat (12) step();
        run_one(4'd9, 4'd9, 8'h51);

        // Back-to-back: Start held into DONE launches the next multiply
        bus.Start = 1'b1;
        bus.A     = 4'd6;
        bus.B     = 4'd6;
        push_exp(4'd6, 4'd6, 8'h24);
        step();
        bus.A = 4'd2;
        bus.B = 4'd3;
        for (int i = 0; i < 20 && !bus.Done; i++) step();
        check("b2b_first_done", 64'(bus.Done), 64'd1);
        push_exp(4'd2, 4'd3, 8'h06);
        step();
        bus.Start = 1'b0;
        wait_idle(8'h06);
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
